// File: rtl/rr_req_arbiter.sv
// Eight-way round-robin arbiter: registered one-hot grant, binary grant index, grant hold.
// Optional owner hold limit with forced release is enabled by defining HOLD_TIMEOUT_EN.
module rr_req_arbiter #(
   parameter int unsigned N_REQ    = 8,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     grant_valid,
   output logic                     preempt
);

   localparam int unsigned IW = $clog2(N_REQ);

`ifdef HOLD_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   typedef enum logic {IDLE, OWN} state_t;

   state_t           state, state_n;
   logic [IW-1:0]    ptr, ptr_n;
   logic [7:0]       hold_cnt, hold_cnt_n;
   logic [N_REQ-1:0] grant_n;
   logic [IW-1:0]    grant_id_n;
   logic             grant_valid_n, preempt_n;

   logic [N_REQ-1:0] cand;
   logic             win_found;
   logic [IW-1:0]    win_id;
   logic             take;

   // The owner is always masked out of the candidate set; every path that uses the
   // winner is a re-arbitration that must exclude the current owner.
   always_comb begin
      cand = req;
      if (state == OWN) cand[grant_id] = 1'b0;
   end

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!win_found && cand[IW'((32'(ptr) + i) % N_REQ)]) begin
            win_found = 1'b1;
            win_id    = IW'((32'(ptr) + i) % N_REQ);
         end
      end
   end

   always_comb begin
      state_n       = state;
      ptr_n         = ptr;
      hold_cnt_n    = hold_cnt;
      grant_n       = grant;
      grant_id_n    = grant_id;
      grant_valid_n = grant_valid;
      preempt_n     = 1'b0;
      take          = 1'b0;

      case (state)
         IDLE: take = win_found;
         OWN: begin
            if (!req[grant_id]) begin
               if (win_found) begin
                  take = 1'b1;
               end else begin
                  state_n       = IDLE;
                  grant_n       = '0;
                  grant_id_n    = '0;
                  grant_valid_n = 1'b0;
               end
            end else if (TIMEOUT_EN && hold_cnt == 8'(MAX_HOLD - 1)) begin
               if (win_found) begin
                  take      = 1'b1;
                  preempt_n = 1'b1;
               end else begin
                  hold_cnt_n = '0;
               end
            end else if (hold_cnt != '1) begin
               hold_cnt_n = hold_cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (take) begin
         state_n         = OWN;
         grant_n         = '0;
         grant_n[win_id] = 1'b1;
         grant_id_n      = win_id;
         grant_valid_n   = 1'b1;
         ptr_n           = (win_id == IW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
         hold_cnt_n      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         hold_cnt    <= '0;
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         preempt     <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         hold_cnt    <= hold_cnt_n;
         grant       <= grant_n;
         grant_id    <= grant_id_n;
         grant_valid <= grant_valid_n;
         preempt     <= preempt_n;
      end
   end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Randomized and directed bench for rr_req_arbiter against a behavioural owner/pointer model.
// Follows HOLD_TIMEOUT_EN the same way the design does.
module tb_rr_req_arbiter;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_id;
   logic       grant_valid;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   // Reference state: owner index (-1 = none), next-priority requester, cycles held.
   int m_owner, m_ptr, m_hold;
   bit m_pre;

`ifdef HOLD_TIMEOUT_EN
   localparam bit TO = 1'b1;
`else
   localparam bit TO = 1'b0;
`endif

   rr_req_arbiter #(.N_REQ(8), .MAX_HOLD(MAXH)) dut (
      .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_id(grant_id),
      .grant_valid(grant_valid), .preempt(preempt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Closest requester at or after m_ptr in circular distance, skipping excl.
   function automatic int pick(input logic [7:0] r, input int excl);
      int best = -1;
      int bestd = 99;
      for (int i = 0; i < 8; i++) begin
         if (r[i] && i != excl && ((i - m_ptr + 8) % 8) < bestd) begin
            bestd = (i - m_ptr + 8) % 8;
            best  = i;
         end
      end
      return best;
   endfunction

   task automatic award(input int w);
      m_owner = w;
      m_ptr   = (w + 1) % 8;
      m_hold  = 0;
   endtask

   task automatic model_step(input logic [7:0] r, input logic rs);
      int w;
      m_pre = 1'b0;
      if (rs) begin
         m_owner = -1; m_ptr = 0; m_hold = 0;
      end else if (m_owner < 0) begin
         w = pick(r, -1);
         if (w >= 0) award(w);
      end else if (!r[m_owner]) begin
         w = pick(r, m_owner);
         if (w >= 0) award(w);
         else m_owner = -1;
      end else if (TO && m_hold == MAXH - 1) begin
         w = pick(r, m_owner);
         if (w >= 0) begin award(w); m_pre = 1'b1; end
         else m_hold = 0;
      end else begin
         m_hold = (m_hold < 255) ? m_hold + 1 : 255;
      end
   endtask

   task automatic cycle(input logic [7:0] r, input logic rs);
      req = r;
      rst = rs;
      @(posedge clk);
      model_step(r, rs);
      #1;
      check("grant",       grant,       (m_owner < 0) ? 0 : (1 << m_owner));
      check("grant_id",    grant_id,    (m_owner < 0) ? 0 : m_owner);
      check("grant_valid", grant_valid, (m_owner >= 0) ? 1 : 0);
      check("preempt",     preempt,     m_pre);
   endtask

   initial begin
      logic [7:0] r, prev;
      int own_cnt, last_owner, k;
      m_owner = -1; m_ptr = 0; m_hold = 0; m_pre = 1'b0;
      req = '0; rst = 1'b1;

      // Reset, idle, then reset mid-ownership
      repeat (2) cycle(8'h00, 1'b1);
      repeat (5) cycle(8'h00, 1'b0);
      repeat (3) cycle(8'h01, 1'b0);
      cycle(8'h01, 1'b1);
      check("rst_mid_own", {grant_valid, grant}, 0);
      cycle(8'h80 | 8'h01, 1'b0);
      check("ptr0_after_rst", grant_id, 0);

      // Direct hand-over without idle gap
      cycle(8'h00, 1'b1);
      cycle(8'b10100010, 1'b0);
      check("s2_first", grant_id, 1);
      cycle(8'b10100000, 1'b0);
      check("s2_second", grant_id, 5);
      cycle(8'b10000000, 1'b0);
      check("s2_third", grant_id, 7);
      cycle(8'b00000011, 1'b0);
      check("s2_wrap_ptr0", grant_id, 0);

      // Fairness with all requesters active
      cycle(8'h00, 1'b1);
      own_cnt = 0; last_owner = -1; k = 0;
      for (int c = 0; c < 60 && k < 9; c++) begin
         r = 8'hFF;
         if (m_owner >= 0 && own_cnt >= 2) r[m_owner] = 1'b0;
         cycle(r, 1'b0);
         if (m_owner != last_owner) begin
            check("fair_seq", grant_id, k % 8);
            k++;
            own_cnt = 1;
            last_owner = m_owner;
         end else begin
            own_cnt++;
         end
      end
      check("fair_count", k, 9);

      // Pointer wrap past requester 7
      cycle(8'h00, 1'b1);
      cycle(8'h20, 1'b0);
      cycle(8'h05, 1'b0);
      check("s4_wrap", grant_id, 0);
      cycle(8'h04, 1'b0);
      check("s4_next", grant_id, 2);

      // Long hold: forced release only with the timeout feature
      cycle(8'h00, 1'b1);
      repeat (12) cycle(8'b00001001, 1'b0);
      cycle(8'h00, 1'b1);
      repeat (12) cycle(8'b00000001, 1'b0);
      cycle(8'h00, 1'b1);
      for (int c = 0; c < 100; c++) begin
         cycle(8'b00001001, 1'b0);
         if (!TO) begin
            check("s6_hold", grant_id, 0);
         end
      end

      // Randomized traffic with occasional holds and resets
      cycle(8'h00, 1'b1);
      prev = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
         else r = prev;
         prev = r;
         cycle(r, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
